// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 read master for the GPU DMA path: fetches one lane's words in bursts that never
// cross a 1 KB boundary and streams them to that lane with a valid/next handshake.
module painterengine_gpu_dma_reader #(
    parameter int PARAM_DATA_ALIGN = 32,
    parameter int PARAM_TIMEOUT    = 256
) (
    input  logic         i_wire_clock,
    input  logic         i_wire_resetn,
    input  logic [3:0]   i_wire_router,
    output logic         o_wire_done,
    input  logic [127:0] i_wire_address,
    input  logic [127:0] i_wire_length,
    output logic [127:0] o_wire_data,
    output logic [3:0]   o_wire_data_valid,
    input  logic [3:0]   i_wire_data_next,
    output logic         o_wire_error,
    output logic [2:0]   o_wire_error_type,
    output logic         o_wire_M_AXI_ARID,
    output logic [31:0]  o_wire_M_AXI_ARADDR,
    output logic [7:0]   o_wire_M_AXI_ARLEN,
    output logic [2:0]   o_wire_M_AXI_ARSIZE,
    output logic [1:0]   o_wire_M_AXI_ARBURST,
    output logic         o_wire_M_AXI_ARLOCK,
    output logic [3:0]   o_wire_M_AXI_ARCACHE,
    output logic [2:0]   o_wire_M_AXI_ARPROT,
    output logic [3:0]   o_wire_M_AXI_ARQOS,
    output logic         o_wire_M_AXI_ARVALID,
    input  logic         i_wire_M_AXI_ARREADY,
    input  logic         i_wire_M_AXI_RID,
    input  logic [31:0]  i_wire_M_AXI_RDATA,
    input  logic [1:0]   i_wire_M_AXI_RRESP,
    input  logic         i_wire_M_AXI_RLAST,
    input  logic         i_wire_M_AXI_RVALID,
    output logic         o_wire_M_AXI_RREADY
);
    typedef enum logic [2:0] {
        ST_ROUTING, ST_CHECK, ST_CALC, ST_ADDR, ST_DATA, ST_DONE, ST_ERROR
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(PARAM_TIMEOUT - 1);
    localparam logic [31:0] WORD_BYTES   = 32'(PARAM_DATA_ALIGN / 8);

    state_t      state, state_next;
    logic [2:0]  error_code;
    logic [1:0]  idx, idx_sel;
    logic        route_ok;
    logic [31:0] address, length, offset, timer;
    logic [31:0] araddr;
    logic [7:0]  arlen, beat;
    logic        arvalid, done, error;
    logic [2:0]  error_type;
    logic [31:0] waddr, remaining, beats, offset_next;
    logic [8:0]  room;
    logic        handshake, last_beat, timed_out;
    logic        unused_ok;

    assign unused_ok = i_wire_M_AXI_RID;

    assign o_wire_M_AXI_ARID    = 1'b0;
    assign o_wire_M_AXI_ARSIZE  = 3'b010;
    assign o_wire_M_AXI_ARBURST = 2'b01;
    assign o_wire_M_AXI_ARLOCK  = 1'b0;
    assign o_wire_M_AXI_ARCACHE = 4'b0010;
    assign o_wire_M_AXI_ARPROT  = 3'b000;
    assign o_wire_M_AXI_ARQOS   = 4'b0000;
    assign o_wire_M_AXI_ARADDR  = araddr;
    assign o_wire_M_AXI_ARLEN   = arlen;
    assign o_wire_M_AXI_ARVALID = arvalid;
    assign o_wire_done          = done;
    assign o_wire_error         = error;
    assign o_wire_error_type    = error_type;
    assign o_wire_M_AXI_RREADY  = (state == ST_DATA) && i_wire_data_next[idx];

    always_comb begin
        o_wire_data       = '0;
        o_wire_data_valid = '0;
        if (state == ST_DATA) begin
            o_wire_data[32*idx +: 32] = i_wire_M_AXI_RDATA;
            o_wire_data_valid[idx]    = i_wire_M_AXI_RVALID;
        end
    end

    always_comb begin
        idx_sel  = 2'd0;
        route_ok = 1'b1;
        case (i_wire_router)
            4'b0001: idx_sel = 2'd0;
            4'b0010: idx_sel = 2'd1;
            4'b0100: idx_sel = 2'd2;
            4'b1000: idx_sel = 2'd3;
            default: route_ok = 1'b0;
        endcase

        // Burst is clipped to the words left before the next 1 KB boundary.
        waddr       = address + offset * WORD_BYTES;
        room        = 9'd256 - {1'b0, waddr[9:2]};
        remaining   = length - offset;
        beats       = (remaining < {23'd0, room}) ? remaining : {23'd0, room};
        handshake   = i_wire_M_AXI_RVALID && o_wire_M_AXI_RREADY;
        last_beat   = (beat == arlen);
        offset_next = offset + {24'd0, arlen} + 32'd1;
        timed_out   = (timer == TIMEOUT_LAST);

        state_next = state;
        error_code = 3'd0;
        case (state)
            ST_ROUTING: begin
                if (!route_ok) begin
                    state_next = ST_ERROR;
                    error_code = 3'd1;
                end else begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (address[1:0] != 2'b00) begin
                    state_next = ST_ERROR;
                    error_code = 3'd2;
                end else if (length == 32'd0) begin
                    state_next = ST_ERROR;
                    error_code = 3'd3;
                end else begin
                    state_next = ST_CALC;
                end
            end
            ST_CALC: state_next = ST_ADDR;
            ST_ADDR: begin
                if (i_wire_M_AXI_ARREADY) begin
                    state_next = ST_DATA;
                end else if (timed_out) begin
                    state_next = ST_ERROR;
                    error_code = 3'd4;
                end
            end
            ST_DATA: begin
                if (handshake) begin
                    if (i_wire_M_AXI_RRESP[1]) begin
                        state_next = ST_ERROR;
                        error_code = 3'd6;
                    end else if (i_wire_M_AXI_RLAST != last_beat) begin
                        state_next = ST_ERROR;
                        error_code = 3'd7;
                    end else if (last_beat) begin
                        state_next = (offset_next >= length) ? ST_DONE : ST_CALC;
                    end
                end else if (timed_out) begin
                    state_next = ST_ERROR;
                    error_code = 3'd5;
                end
            end
            default: state_next = state;
        endcase
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state <= ST_ROUTING;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            idx        <= 2'd0;
            address    <= '0;
            length     <= '0;
            offset     <= '0;
            timer      <= '0;
            araddr     <= '0;
            arlen      <= '0;
            arvalid    <= 1'b0;
            beat       <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            error_type <= 3'd0;
        end else begin
            case (state)
                ST_ROUTING: begin
                    idx     <= idx_sel;
                    address <= i_wire_address[32*idx_sel +: 32];
                    length  <= i_wire_length[32*idx_sel +: 32];
                end
                ST_CALC: begin
                    araddr  <= waddr;
                    arlen   <= 8'(beats - 32'd1);
                    arvalid <= 1'b1;
                    timer   <= '0;
                end
                ST_ADDR: begin
                    if (i_wire_M_AXI_ARREADY) begin
                        arvalid <= 1'b0;
                        beat    <= '0;
                        timer   <= '0;
                    end else if (timed_out) begin
                        arvalid <= 1'b0;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                ST_DATA: begin
                    if (handshake) begin
                        beat  <= beat + 8'd1;
                        timer <= '0;
                        if (last_beat) begin
                            offset <= offset_next;
                        end
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                default: ;
            endcase
            if (state_next == ST_DONE) begin
                done <= 1'b1;
            end
            if (state != ST_ERROR && state_next == ST_ERROR) begin
                error      <= 1'b1;
                error_type <= error_code;
            end
        end
    end
endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Directed bench for painterengine_gpu_dma_reader: an in-bench AXI read slave drives
// fixed data patterns while each scenario checks bursts, lane streaming and error codes.
module tb_painterengine_gpu_dma_reader;
    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [3:0]   router = '0;
    logic         done;
    logic [127:0] address = '0;
    logic [127:0] length = '0;
    logic [127:0] data;
    logic [3:0]   data_valid;
    logic [3:0]   data_next = '0;
    logic         error;
    logic [2:0]   error_type;
    logic         arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arlock;
    logic [3:0]   arcache;
    logic [2:0]   arprot;
    logic [3:0]   arqos;
    logic         arvalid;
    logic         arready = 1'b0;
    logic [31:0]  rdata = '0;
    logic [1:0]   rresp = '0;
    logic         rlast = 1'b0;
    logic         rvalid = 1'b0;
    logic         rready;

    painterengine_gpu_dma_reader #(.PARAM_DATA_ALIGN(32), .PARAM_TIMEOUT(256)) dut (
        .i_wire_clock(clk), .i_wire_resetn(resetn), .i_wire_router(router),
        .o_wire_done(done), .i_wire_address(address), .i_wire_length(length),
        .o_wire_data(data), .o_wire_data_valid(data_valid), .i_wire_data_next(data_next),
        .o_wire_error(error), .o_wire_error_type(error_type),
        .o_wire_M_AXI_ARID(arid), .o_wire_M_AXI_ARADDR(araddr), .o_wire_M_AXI_ARLEN(arlen),
        .o_wire_M_AXI_ARSIZE(arsize), .o_wire_M_AXI_ARBURST(arburst),
        .o_wire_M_AXI_ARLOCK(arlock), .o_wire_M_AXI_ARCACHE(arcache),
        .o_wire_M_AXI_ARPROT(arprot), .o_wire_M_AXI_ARQOS(arqos),
        .o_wire_M_AXI_ARVALID(arvalid), .i_wire_M_AXI_ARREADY(arready),
        .i_wire_M_AXI_RID(1'b0), .i_wire_M_AXI_RDATA(rdata), .i_wire_M_AXI_RRESP(rresp),
        .i_wire_M_AXI_RLAST(rlast), .i_wire_M_AXI_RVALID(rvalid),
        .o_wire_M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        cfg_arready;
    logic        cfg_next;
    int          cfg_bad_beat;
    logic [31:0] cfg_base;

    int          ar_cnt;
    logic [31:0] ar_addr_log [8];
    logic [7:0]  ar_len_log [8];
    int          hs_cnt;
    int          first_ar;
    int          arvalid_cyc;
    logic        rready_seen;

    // Non-selected lanes hold a misaligned address so a wrong lane pick shows up as an error.
    task automatic setup(input logic [3:0] rt, input int lane, input logic [31:0] addr,
                         input logic [31:0] len);
        router = rt;
        for (int i = 0; i < 4; i++) begin
            address[i*32 +: 32] = 32'h0000_1003;
            length[i*32 +: 32]  = 32'd9;
        end
        address[lane*32 +: 32] = addr;
        length[lane*32 +: 32]  = len;
        cfg_arready  = 1'b1;
        cfg_next     = 1'b1;
        cfg_bad_beat = -1;
        cfg_base     = 32'h0000_00A0;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rlast     = 1'b0;
        rdata     = '0;
        rresp     = '0;
        data_next = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic serve(input int lane, input int max_cyc);
        logic        have;
        logic [7:0]  cur_len;
        int          bi;
        int          g;
        logic [127:0] exp_data;
        logic [3:0]   exp_valid;
        have = 1'b0; cur_len = '0; bi = 0; g = 0;
        ar_cnt = 0; hs_cnt = 0; first_ar = -1; arvalid_cyc = 0; rready_seen = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            arready   = cfg_arready;
            data_next = cfg_next ? (4'b0001 << lane) : 4'b0000;
            rvalid    = have;
            rdata     = cfg_base + 32'(g);
            rlast     = have && (bi == int'(cur_len));
            rresp     = (have && g == cfg_bad_beat) ? 2'b10 : 2'b00;
            #1;
            if (done || error) break;
            if (arvalid) begin
                arvalid_cyc++;
                if (first_ar < 0) first_ar = c;
            end
            if (rready) rready_seen = 1'b1;
            if (rvalid && rready) begin
                exp_data  = 128'(rdata) << (32 * lane);
                exp_valid = 4'b0001 << lane;
                checks++;
                if (data !== exp_data || data_valid !== exp_valid) begin
                    failures++;
                    $display("FAIL lane_beat%0d data=%h valid=%b expected data=%h valid=%b",
                             g, data, data_valid, exp_data, exp_valid);
                end
                hs_cnt++;
                if (rlast) have = 1'b0;
                bi++;
                g++;
            end
            if (arvalid && arready) begin
                if (ar_cnt < 8) begin
                    ar_addr_log[ar_cnt] = araddr;
                    ar_len_log[ar_cnt]  = arlen;
                end
                ar_cnt++;
                have    = 1'b1;
                cur_len = arlen;
                bi      = 0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({arvalid, done, error, error_type} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got arvalid=%b done=%b error=%b type=%0d expected all 0",
                     arvalid, done, error, error_type);
        end
        checks++;
        if (araddr !== 32'h0 || arlen !== 8'h0) begin
            failures++;
            $display("FAIL reset_ar got araddr=%h arlen=%h expected 0/0", araddr, arlen);
        end
        checks++;
        if (data !== 128'h0 || data_valid !== 4'h0 || rready !== 1'b0) begin
            failures++;
            $display("FAIL reset_data got data=%h valid=%b rready=%b expected 0",
                     data, data_valid, rready);
        end
        checks++;
        if ({arid, arsize, arburst, arlock, arcache, arprot, arqos} !== {1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b0, 4'b0}) begin
            failures++;
            $display("FAIL ar_constants got size=%b burst=%b cache=%b expected 010/01/0010",
                     arsize, arburst, arcache);
        end
    endtask

    task automatic test_single_burst();
        setup(4'b0010, 1, 32'h1000_0000, 32'd4);
        do_reset();
        serve(1, 100);
        checks++;
        if (first_ar !== 3) begin
            failures++;
            $display("FAIL first_ar_latency got=%0d expected=3", first_ar);
        end
        checks++;
        if (ar_cnt !== 1 || ar_addr_log[0] !== 32'h1000_0000 || ar_len_log[0] !== 8'd3) begin
            failures++;
            $display("FAIL single_ar got count=%0d addr=%h len=%0d expected 1/10000000/3",
                     ar_cnt, ar_addr_log[0], ar_len_log[0]);
        end
        checks++;
        if (hs_cnt !== 4 || done !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL single_done got beats=%0d done=%b error=%b expected 4/1/0",
                     hs_cnt, done, error);
        end
    endtask

    task automatic test_boundary_split();
        setup(4'b0001, 0, 32'h0000_03F8, 32'd4);
        do_reset();
        serve(0, 100);
        checks++;
        if (ar_cnt !== 2 || ar_addr_log[0] !== 32'h3F8 || ar_len_log[0] !== 8'd1 ||
            ar_addr_log[1] !== 32'h400 || ar_len_log[1] !== 8'd1) begin
            failures++;
            $display("FAIL split_ars got count=%0d %h/%0d %h/%0d expected 2 3f8/1 400/1",
                     ar_cnt, ar_addr_log[0], ar_len_log[0], ar_addr_log[1], ar_len_log[1]);
        end
        checks++;
        if (done !== 1'b1 || hs_cnt !== 4) begin
            failures++;
            $display("FAIL split_done got done=%b beats=%0d expected 1/4", done, hs_cnt);
        end
    endtask

    task automatic test_long_transfer();
        setup(4'b0100, 2, 32'h0000_0000, 32'd300);
        do_reset();
        serve(2, 1000);
        checks++;
        if (ar_cnt !== 2 || ar_addr_log[0] !== 32'h0 || ar_len_log[0] !== 8'd255 ||
            ar_addr_log[1] !== 32'h400 || ar_len_log[1] !== 8'd43) begin
            failures++;
            $display("FAIL long_ars got count=%0d %h/%0d %h/%0d expected 2 0/255 400/43",
                     ar_cnt, ar_addr_log[0], ar_len_log[0], ar_addr_log[1], ar_len_log[1]);
        end
        checks++;
        if (hs_cnt !== 300 || done !== 1'b1) begin
            failures++;
            $display("FAIL long_done got beats=%0d done=%b expected 300/1", hs_cnt, done);
        end
    endtask

    task automatic test_setup_errors();
        logic [3:0]  rts  [3] = '{4'b0011, 4'b1000, 4'b1000};
        logic [31:0] adrs [3] = '{32'h0, 32'h0000_0002, 32'h0000_0100};
        logic [31:0] lens [3] = '{32'd4, 32'd4, 32'd0};
        logic [2:0]  exps [3] = '{3'd1, 3'd2, 3'd3};
        for (int k = 0; k < 3; k++) begin
            setup(rts[k], 3, adrs[k], lens[k]);
            do_reset();
            serve(3, 20);
            checks++;
            if (error !== 1'b1 || error_type !== exps[k] || ar_cnt !== 0 || arvalid_cyc !== 0) begin
                failures++;
                $display("FAIL setup_err%0d got error=%b type=%0d arvalid_cycles=%0d expected 1/%0d/0",
                         k, error, error_type, arvalid_cyc, exps[k]);
            end
        end
    endtask

    task automatic test_rresp_error();
        setup(4'b1000, 3, 32'h0000_0100, 32'd8);
        cfg_bad_beat = 2;
        do_reset();
        serve(3, 100);
        checks++;
        if (error !== 1'b1 || error_type !== 3'd6 || done !== 1'b0 || hs_cnt !== 3) begin
            failures++;
            $display("FAIL rresp_err got error=%b type=%0d done=%b beats=%0d expected 1/6/0/3",
                     error, error_type, done, hs_cnt);
        end
    endtask

    task automatic test_data_timeout();
        setup(4'b0010, 1, 32'h0000_0040, 32'd4);
        cfg_next = 1'b0;
        do_reset();
        serve(1, 400);
        checks++;
        if (error !== 1'b1 || error_type !== 3'd5 || rready_seen !== 1'b0 || hs_cnt !== 0) begin
            failures++;
            $display("FAIL data_timeout got error=%b type=%0d rready_seen=%b beats=%0d expected 1/5/0/0",
                     error, error_type, rready_seen, hs_cnt);
        end
    endtask

    task automatic test_ar_timeout();
        setup(4'b0001, 0, 32'h0000_0000, 32'd4);
        cfg_arready = 1'b0;
        do_reset();
        serve(0, 400);
        checks++;
        if (error !== 1'b1 || error_type !== 3'd4 || arvalid_cyc !== 256 || arvalid !== 1'b0) begin
            failures++;
            $display("FAIL ar_timeout got error=%b type=%0d arvalid_cycles=%0d arvalid=%b expected 1/4/256/0",
                     error, error_type, arvalid_cyc, arvalid);
        end
    endtask

    task automatic test_reset_mid_burst();
        setup(4'b0100, 2, 32'h0000_0000, 32'd300);
        do_reset();
        serve(2, 15);
        checks++;
        if (rready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL mid_burst_active got rready=%b done=%b expected 1/0", rready, done);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (arvalid !== 1'b0 || rready !== 1'b0 || data_valid !== 4'b0) begin
            failures++;
            $display("FAIL mid_reset_drop got arvalid=%b rready=%b valid=%b expected 0/0/0",
                     arvalid, rready, data_valid);
        end
        setup(4'b0010, 1, 32'h2000_0010, 32'd2);
        cfg_base = 32'h0000_5500;
        do_reset();
        serve(1, 100);
        checks++;
        if (first_ar !== 3 || ar_cnt !== 1 || ar_addr_log[0] !== 32'h2000_0010 ||
            ar_len_log[0] !== 8'd1 || done !== 1'b1) begin
            failures++;
            $display("FAIL restart got first_ar=%0d count=%0d addr=%h len=%0d done=%b expected 3/1/20000010/1/1",
                     first_ar, ar_cnt, ar_addr_log[0], ar_len_log[0], done);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_boundary_split();
        test_long_transfer();
        test_setup_errors();
        test_rresp_error();
        test_data_timeout();
        test_ar_timeout();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
